iot_fleet_monitor: RTL
======================

IOT_FLEET_MONITOR -- requirements
Module: iot_fleet_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the per-channel counter width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter NCH, default 4, meaning the number of independent device channels (NCH >= 1).
REQ-003 The block SHALL have parameter SATURATE, default 0, meaning 0 = wrap-around and 1 = clamp at 0 / 2^WIDTH-1.
REQ-004 The block SHALL have parameters ALARM_HI (default 600), ALARM_LO (default 400) and HOLD (default 4), meaning the alarm set threshold, the alarm clear threshold and the number of qualifying cycles before the alarm is raised.
REQ-005 The block SHALL have port clk, input, 1 bit, the clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit, reset, synchronous, active-high.
REQ-007 The block SHALL have port change, input, NCH bits, per-channel event strobe.
REQ-008 The block SHALL have port on_off, input, NCH bits, per-channel direction (1 = device on = up, 0 = device off = down).
REQ-009 The block SHALL have port clear_flags, input, 1 bit, which clears all sticky boundary flags.
REQ-010 The block SHALL have port count_out, output, NCH*WIDTH bits, where channel i occupies bits [i*WIDTH +: WIDTH].
REQ-011 The block SHALL have port total_out, output, WIDTH+$clog2(NCH)+1 bits, the registered sum of all channel counts.
REQ-012 The block SHALL have port bound_flag, output, NCH bits, a sticky per-channel wrap/clamp indicator.
REQ-013 The block SHALL have port alarm, output, 1 bit, the registered high-occupancy alarm.

Function
REQ-014 Per channel, change=0 SHALL hold the count, change=1 with on_off=1 SHALL increment it, and change=1 with on_off=0 SHALL decrement it; each update is visible the cycle after the clock edge.
REQ-015 With SATURATE=0, an increment from 2^WIDTH-1 SHALL give 0 and a decrement from 0 SHALL give 2^WIDTH-1 (modulo arithmetic).
REQ-016 With SATURATE=1, an increment at 2^WIDTH-1 or a decrement at 0 SHALL leave the count unchanged.
REQ-017 Any wrap or clamp event on channel i SHALL set bound_flag[i] on the same edge that would update the count; the flag stays set until clear_flags or rst.
REQ-018 When clear_flags and a new boundary event coincide on channel i, bound_flag[i] SHALL end the cycle set (set wins).
REQ-019 Channels SHALL update independently; simultaneous events on any subset of channels SHALL all take effect in the same cycle.
REQ-020 total_out SHALL equal the zero-extended sum of count_out one cycle later (the registered sum of the previous cycle's counts), so it lags an event by 2 edges.
REQ-021 The alarm FSM SHALL have states NORMAL, ARMING and ALARM; alarm=1 only in ALARM.
REQ-022 NORMAL -> ARMING SHALL occur when total_out >= ALARM_HI, with the qualify counter loaded to 1.
REQ-023 In ARMING, if total_out >= ALARM_HI the counter SHALL increment and the FSM SHALL enter ALARM when the counter reaches HOLD; if total_out < ALARM_HI the FSM SHALL return to NORMAL.
REQ-024 ALARM -> NORMAL SHALL occur when total_out <= ALARM_LO; values strictly between ALARM_LO and ALARM_HI SHALL hold the current ALARM state (hysteresis).
REQ-025 HOLD=1 SHALL make ARMING last exactly one cycle; ALARM_LO >= ALARM_HI is illegal and SHALL be flagged by an elaboration-time check.

Reset
REQ-026 When rst=1 at a clock edge, all counts, total_out, bound_flag and alarm SHALL be 0, the FSM SHALL be in NORMAL and the qualify counter 0; rst overrides change and clear_flags.
REQ-027 rst asserted mid-ARMING or mid-ALARM SHALL abort to NORMAL with no residual count.

Structure
REQ-028 Package iot_mon_pkg SHALL hold the FSM state typedef (NORMAL, ARMING, ALARM) and the default parameter constants.
REQ-029 The per-channel counter with its bound flag SHALL be sub-module iot_mon_channel, instantiated NCH times by generate; the adder tree and FSM remain in the top.

Verification
REQ-030 The bench SHALL check: rst, then ch0 change=1/on_off=1 for 3 cycles -> count0=3, and total_out=3 two edges after the last event.
REQ-031 The bench SHALL check: SATURATE=0, ch1 at 255 incremented -> count1=0 and bound_flag[1]=1; ch2 at 0 decremented -> 255.
REQ-032 The bench SHALL check: SATURATE=1, ch0 at 255 incremented -> stays 255 and flag set; clear_flags alongside a new clamp -> flag remains 1.
REQ-033 The bench SHALL check: all 4 channels incrementing in one cycle from 10 -> each reads 11 and total_out=44.
REQ-034 The bench SHALL check: total driven to 600 for 4 cycles -> alarm rises; total dropping to 500 -> alarm held; total at 400 -> alarm falls next cycle; a 3-cycle excursion -> no alarm.
REQ-035 The bench SHALL check: rst asserted while alarm=1 -> alarm=0, all outputs 0 and state NORMAL on the following cycle.

Source files
------------

// File: rtl/iot_mon_pkg.sv
// Shared types and default constants for the IoT fleet occupancy monitor.
package iot_mon_pkg;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_NCH      = 4;
   localparam int DEF_SATURATE = 0;
   localparam int DEF_ALARM_HI = 600;
   localparam int DEF_ALARM_LO = 400;
   localparam int DEF_HOLD     = 4;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      ARMING = 2'd1,
      ALARM  = 2'd2
   } alarm_state_t;

endpackage

// File: rtl/iot_mon_channel.sv
// One device channel: up/down occupancy counter with wrap or clamp at the
// range ends, plus a sticky flag recording that a boundary was hit.
module iot_mon_channel
   import iot_mon_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int SATURATE = DEF_SATURATE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             change,
   input  logic             on_off,
   input  logic             clear_flag,
   output logic [WIDTH-1:0] count,
   output logic             bound_flag
);

   localparam bit SAT = (SATURATE != 0);

   logic at_max;
   logic at_min;
   logic hit_bound;

   assign at_max    = &count;
   assign at_min    = ~|count;
   assign hit_bound = change & (on_off ? at_max : at_min);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         bound_flag <= 1'b0;
      end else begin
         // A clamped update leaves the count alone; otherwise modulo arithmetic.
         if (change && !(hit_bound && SAT))
            count <= on_off ? count + 1'b1 : count - 1'b1;
         // A new boundary event beats a simultaneous clear.
         if (hit_bound)
            bound_flag <= 1'b1;
         else if (clear_flag)
            bound_flag <= 1'b0;
      end
   end

endmodule

// File: rtl/iot_fleet_monitor.sv
// Fleet monitor: NCH independent device counters, a registered total and a
// hysteretic high-occupancy alarm that must qualify for HOLD cycles.
module iot_fleet_monitor
   import iot_mon_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NCH      = DEF_NCH,
   parameter int SATURATE = DEF_SATURATE,
   parameter int ALARM_HI = DEF_ALARM_HI,
   parameter int ALARM_LO = DEF_ALARM_LO,
   parameter int HOLD     = DEF_HOLD
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NCH-1:0]                change,
   input  logic [NCH-1:0]                on_off,
   input  logic                          clear_flags,
   output logic [NCH*WIDTH-1:0]          count_out,
   output logic [WIDTH+$clog2(NCH):0]    total_out,
   output logic [NCH-1:0]                bound_flag,
   output logic                          alarm
);

   localparam int TOTAL_W = WIDTH + $clog2(NCH) + 1;
   // Two spare states above HOLD keep qual_cnt + 1 from overflowing when HOLD=1.
   localparam int QW      = $clog2(HOLD + 2);

   localparam logic [TOTAL_W-1:0] HI_TH  = TOTAL_W'(ALARM_HI);
   localparam logic [TOTAL_W-1:0] LO_TH  = TOTAL_W'(ALARM_LO);
   localparam logic [QW-1:0]      HOLD_Q = QW'(HOLD);

   generate
      if (ALARM_LO >= ALARM_HI) begin : g_bad_thresholds
         $error("iot_fleet_monitor: ALARM_LO must be below ALARM_HI");
      end
      if (WIDTH < 2 || NCH < 1 || HOLD < 1) begin : g_bad_sizes
         $error("iot_fleet_monitor: WIDTH >= 2, NCH >= 1 and HOLD >= 1 required");
      end
   endgenerate

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      iot_mon_channel #(
         .WIDTH    (WIDTH),
         .SATURATE (SATURATE)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .change     (change[i]),
         .on_off     (on_off[i]),
         .clear_flag (clear_flags),
         .count      (count_out[i*WIDTH +: WIDTH]),
         .bound_flag (bound_flag[i])
      );
   end

   logic [TOTAL_W-1:0] sum;

   // NOTE: combinational outputs get a default before the loop so no latch is inferred.
   always_comb begin
      sum = '0;
      for (int i = 0; i < NCH; i++)
         sum = sum + TOTAL_W'(count_out[i*WIDTH +: WIDTH]);
   end

   alarm_state_t  state;
   logic [QW-1:0] qual_cnt;
   logic [QW-1:0] qual_nxt;
   logic          above_hi;
   logic          below_lo;

   assign qual_nxt = qual_cnt + 1'b1;
   assign above_hi = (total_out >= HI_TH);
   assign below_lo = (total_out <= LO_TH);

   always_ff @(posedge clk) begin
      if (rst) begin
         total_out <= '0;
         state     <= NORMAL;
         qual_cnt  <= '0;
         alarm     <= 1'b0;
      end else begin
         total_out <= sum;
         case (state)
            NORMAL: begin
               if (above_hi) begin
                  state    <= ARMING;
                  qual_cnt <= QW'(1);
               end
            end
            ARMING: begin
               if (above_hi) begin
                  qual_cnt <= qual_nxt;
                  if (qual_nxt >= HOLD_Q) begin
                     state <= ALARM;
                     alarm <= 1'b1;
                  end
               end else begin
                  state    <= NORMAL;
                  qual_cnt <= '0;
               end
            end
            ALARM: begin
               // Totals between the thresholds keep the alarm raised.
               if (below_lo) begin
                  state    <= NORMAL;
                  qual_cnt <= '0;
                  alarm    <= 1'b0;
               end
            end
            default: begin
               state    <= NORMAL;
               qual_cnt <= '0;
               alarm    <= 1'b0;
            end
         endcase
      end
   end

endmodule
